// File: rtl/unlock_sequencer.sv
// Accepts a code from the host, streams it MSB-first into an external unlock FSM and applies its verdict.
// Define UNLOCK_SEQ_STATS_EN to add saturating ok_total/fail_total attempt counters.
module unlock_sequencer #(
    parameter int CODE_W         = 4,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 100,
    parameter int OPEN_CYCLES    = 50
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             code_valid,
    input  logic [CODE_W-1:0]                code_data,
    output logic                             code_ready,
    output logic                             fsm_clear,
    output logic                             serial_ready,
    output logic                             serial_valid,
    output logic                             serial_data,
    input  logic                             unlock,
    input  logic                             pwd_incorrect,
    output logic                             door_open,
    output logic                             locked_out,
    output logic [$clog2(MAX_FAILS+1)-1:0]   fail_cnt,
    output logic                             result_valid,
`ifdef UNLOCK_SEQ_STATS_EN
    output logic [7:0]                       ok_total,
    output logic [7:0]                       fail_total,
`endif
    output logic                             result_ok
);

    localparam int FAIL_W  = $clog2(MAX_FAILS + 1);
    localparam int TMAX    = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
    localparam int TIMER_W = $clog2(TMAX + 1);
    localparam int IDX_W   = (CODE_W > 1) ? $clog2(CODE_W) : 1;

    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(CODE_W - 1);
    localparam logic [FAIL_W-1:0]  FAIL_MAX  = FAIL_W'(MAX_FAILS);
    localparam logic [TIMER_W-1:0] OPEN_LOAD = TIMER_W'(OPEN_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOCK_LOAD = TIMER_W'(LOCKOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, OPEN, LOCKOUT} state_t;

    state_t              r_state;
    logic [CODE_W-1:0]   r_shift;
    logic [IDX_W-1:0]    r_bit_idx;
    logic [TIMER_W-1:0]  r_timer;
    logic [FAIL_W-1:0]   r_fail_cnt;
    logic                r_code_ready;
    logic                r_fsm_clear;
    logic                r_serial_valid;
    logic                r_serial_data;
    logic                r_door_open;
    logic                r_locked_out;
    logic                r_result_valid;
    logic                r_result_ok;

    logic                w_last_bit;
    logic                w_fail;
    logic                w_success;
    logic [FAIL_W-1:0]   w_fail_inc;
    logic                w_lock_trip;

    // An early unlock is ignored; pwd_incorrect wins over unlock on any bit.
    assign w_last_bit  = (r_bit_idx == LAST_IDX);
    assign w_fail      = (r_state == SHIFT) && (pwd_incorrect || (w_last_bit && !unlock));
    assign w_success   = (r_state == SHIFT) && w_last_bit && unlock && !pwd_incorrect;
    assign w_fail_inc  = r_fail_cnt + FAIL_W'(1);
    assign w_lock_trip = (w_fail_inc == FAIL_MAX);

    // NOTE: state and registered outputs use non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_shift        <= '0;
            r_bit_idx      <= '0;
            r_timer        <= '0;
            r_fail_cnt     <= '0;
            r_code_ready   <= 1'b1;
            r_fsm_clear    <= 1'b0;
            r_serial_valid <= 1'b0;
            r_serial_data  <= 1'b0;
            r_door_open    <= 1'b0;
            r_locked_out   <= 1'b0;
            r_result_valid <= 1'b0;
            r_result_ok    <= 1'b0;
        end else begin
            r_fsm_clear    <= 1'b0;
            r_result_valid <= 1'b0;
            r_result_ok    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (code_valid) begin
                        r_shift      <= code_data;
                        r_code_ready <= 1'b0;
                        r_fsm_clear  <= 1'b1;
                        r_state      <= CLEAR;
                    end
                end
                CLEAR: begin
                    r_bit_idx      <= '0;
                    r_serial_valid <= 1'b1;
                    r_serial_data  <= r_shift[CODE_W-1];
                    r_shift        <= r_shift << 1;
                    r_state        <= SHIFT;
                end
                SHIFT: begin
                    if (w_success) begin
                        r_serial_valid <= 1'b0;
                        r_serial_data  <= 1'b0;
                        r_fail_cnt     <= '0;
                        r_result_valid <= 1'b1;
                        r_result_ok    <= 1'b1;
                        r_door_open    <= 1'b1;
                        r_timer        <= OPEN_LOAD;
                        r_state        <= OPEN;
                    end else if (w_fail) begin
                        r_serial_valid <= 1'b0;
                        r_serial_data  <= 1'b0;
                        r_result_valid <= 1'b1;
                        r_fail_cnt     <= w_fail_inc;
                        if (w_lock_trip) begin
                            r_locked_out <= 1'b1;
                            r_timer      <= LOCK_LOAD;
                            r_state      <= LOCKOUT;
                        end else begin
                            r_code_ready <= 1'b1;
                            r_state      <= IDLE;
                        end
                    end else begin
                        r_bit_idx     <= r_bit_idx + IDX_W'(1);
                        r_serial_data <= r_shift[CODE_W-1];
                        r_shift       <= r_shift << 1;
                    end
                end
                OPEN: begin
                    if (r_timer == '0) begin
                        r_door_open  <= 1'b0;
                        r_code_ready <= 1'b1;
                        r_state      <= IDLE;
                    end else begin
                        r_timer <= r_timer - TIMER_W'(1);
                    end
                end
                LOCKOUT: begin
                    if (r_timer == '0) begin
                        r_locked_out <= 1'b0;
                        r_fail_cnt   <= '0;
                        r_code_ready <= 1'b1;
                        r_state      <= IDLE;
                    end else begin
                        r_timer <= r_timer - TIMER_W'(1);
                    end
                end
                default: begin
                    r_code_ready <= 1'b1;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

`ifdef UNLOCK_SEQ_STATS_EN
    logic [7:0] r_ok_total;
    logic [7:0] r_fail_total;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ok_total   <= '0;
            r_fail_total <= '0;
        end else begin
            if (w_success && (r_ok_total != 8'hFF)) r_ok_total <= r_ok_total + 8'd1;
            if (w_fail && (r_fail_total != 8'hFF)) r_fail_total <= r_fail_total + 8'd1;
        end
    end

    assign ok_total   = r_ok_total;
    assign fail_total = r_fail_total;
`endif

    // The FSM consumes a bit every cycle the sequencer presents one.
    assign serial_ready = r_serial_valid;
    assign code_ready   = r_code_ready;
    assign fsm_clear    = r_fsm_clear;
    assign serial_valid = r_serial_valid;
    assign serial_data  = r_serial_data;
    assign door_open    = r_door_open;
    assign locked_out   = r_locked_out;
    assign fail_cnt     = r_fail_cnt;
    assign result_valid = r_result_valid;
    assign result_ok    = r_result_ok;

endmodule

// File: tb/tb_unlock_sequencer.sv
// Self-checking bench for unlock_sequencer: a per-cycle expected-output timeline is
// predicted for each attempt and compared on every falling edge.
module tb_unlock_sequencer;

    localparam int W     = 4;
    localparam int MAXF  = 3;
    localparam int LOCK  = 100;
    localparam int OPENC = 50;
    localparam int MAXC  = 20000;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         code_valid = 1'b0;
    logic [W-1:0] code_data = '0;
    logic         unlock = 1'b0;
    logic         pwd_incorrect = 1'b0;
    logic         code_ready, fsm_clear, serial_ready, serial_valid, serial_data;
    logic         door_open, locked_out, result_valid, result_ok;
    logic [1:0]   fail_cnt;
`ifdef UNLOCK_SEQ_STATS_EN
    logic [7:0]   ok_total, fail_total;
    int           m_ok_tot = 0;
    int           m_fail_tot = 0;
`endif

    unlock_sequencer #(
        .CODE_W(W), .MAX_FAILS(MAXF), .LOCKOUT_CYCLES(LOCK), .OPEN_CYCLES(OPENC)
    ) dut (
        .clk(clk), .reset(reset),
        .code_valid(code_valid), .code_data(code_data), .code_ready(code_ready),
        .fsm_clear(fsm_clear), .serial_ready(serial_ready), .serial_valid(serial_valid),
        .serial_data(serial_data), .unlock(unlock), .pwd_incorrect(pwd_incorrect),
        .door_open(door_open), .locked_out(locked_out), .fail_cnt(fail_cnt),
        .result_valid(result_valid),
`ifdef UNLOCK_SEQ_STATS_EN
        .ok_total(ok_total), .fail_total(fail_total),
`endif
        .result_ok(result_ok)
    );

    typedef struct {
        bit       set;
        bit       code_ready, fsm_clear, serial_ready, serial_valid, serial_data;
        bit       door_open, locked_out, result_valid, result_ok;
        bit [1:0] fail_cnt;
    } exp_t;

    exp_t        tl [MAXC];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          m_free = 0;
    int          m_fail = 0;
    int          mon_open = 0, mon_lock = 0, mon_nbits = 0;
    logic [31:0] mon_bits = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
        end
    endtask

    function automatic logic [10:0] pack_exp(input exp_t e);
        return {e.code_ready, e.fsm_clear, e.serial_ready, e.serial_valid, e.serial_data,
                e.door_open, e.locked_out, e.result_valid, e.result_ok, e.fail_cnt};
    endfunction

    wire [10:0] act_vec = {code_ready, fsm_clear, serial_ready, serial_valid, serial_data,
                           door_open, locked_out, result_valid, result_ok, fail_cnt};

    always @(negedge clk) begin
        if (!reset && cyc < MAXC && tl[cyc].set)
            check($sformatf("cycle %0d outputs", cyc), 32'(act_vec), 32'(pack_exp(tl[cyc])));
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (serial_valid) begin
                mon_bits  <= {mon_bits[30:0], serial_data};
                mon_nbits <= mon_nbits + 1;
            end
            if (door_open)  mon_open <= mon_open + 1;
            if (locked_out) mon_lock <= mon_lock + 1;
        end
    end

    function automatic exp_t busy_e(input int f);
        exp_t e;
        e = '{default: 0};
        e.set = 1'b1;
        e.fail_cnt = 2'(f);
        return e;
    endfunction

    function automatic exp_t idle_e(input int f);
        exp_t e;
        e = busy_e(f);
        e.code_ready = 1'b1;
        return e;
    endfunction

    task automatic fill_idle(input int from, input int to);
        for (int c = from; c <= to; c++) tl[c] = idle_e(m_fail);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Clear cycle after the handshake, then bits 0..last_bit of the code, MSB first.
    task automatic fill_front(input int a, input logic [W-1:0] code, input int last_bit);
        tl[a+1] = busy_e(m_fail);
        tl[a+1].fsm_clear = 1'b1;
        for (int i = 0; i <= last_bit; i++) begin
            tl[a+2+i] = busy_e(m_fail);
            tl[a+2+i].serial_valid = 1'b1;
            tl[a+2+i].serial_ready = 1'b1;
            tl[a+2+i].serial_data  = code[W-1-i];
        end
    endtask

    // um/pm bit i is the FSM response while bit i (in send order) is on the line.
    task automatic attempt(input logic [W-1:0] code, input logic [W-1:0] um,
                           input logic [W-1:0] pm, input int gap, input bit spam);
        int a, d, r, ready_at;
        bit ok, decided;
        a = m_free + gap;
        fill_idle(m_free, a);
        d = W - 1;
        ok = 1'b0;
        decided = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (!decided && pm[i]) begin
                d = i;
                decided = 1'b1;
            end else if (!decided && i == W - 1) begin
                ok = um[i];
                decided = 1'b1;
            end
        end
        fill_front(a, code, d);
        r = a + 3 + d;
        if (ok) begin
            m_fail = 0;
            for (int k = 0; k < OPENC; k++) begin
                tl[r+k] = busy_e(0);
                tl[r+k].door_open = 1'b1;
            end
            tl[r].result_valid = 1'b1;
            tl[r].result_ok = 1'b1;
            m_free = r + OPENC;
            ready_at = r + OPENC;
        end else if (m_fail + 1 == MAXF) begin
            for (int k = 0; k < LOCK; k++) begin
                tl[r+k] = busy_e(MAXF);
                tl[r+k].locked_out = 1'b1;
            end
            tl[r].result_valid = 1'b1;
            m_fail = 0;
            m_free = r + LOCK;
            ready_at = r + LOCK;
        end else begin
            m_fail = m_fail + 1;
            tl[r] = idle_e(m_fail);
            tl[r].result_valid = 1'b1;
            m_free = r + 1;
            ready_at = r;
        end
`ifdef UNLOCK_SEQ_STATS_EN
        if (ok && m_ok_tot < 255) m_ok_tot++;
        if (!ok && m_fail_tot < 255) m_fail_tot++;
`endif
        wait_until(a);
        code_valid = 1'b1;
        code_data = code;
        wait_until(a + 1);
        if (spam) code_data = ~code;
        else code_valid = 1'b0;
        for (int i = 0; i <= d; i++) begin
            wait_until(a + 2 + i);
            unlock = um[i];
            pwd_incorrect = pm[i];
        end
        wait_until(a + 3 + d);
        unlock = 1'b0;
        pwd_incorrect = 1'b0;
        if (spam) begin
            wait_until(ready_at);
            code_valid = 1'b0;
        end
    endtask

    // Call just after a rising edge; outputs must drop while reset is high.
    task automatic pulse_reset(input string tag);
        int c;
        c = cyc;
        #1 reset = 1'b1;
        #1;
        check({tag, " serial_valid in reset"}, 32'(serial_valid), 32'd0);
        check({tag, " result_valid in reset"}, 32'(result_valid), 32'd0);
        @(posedge clk);
        #2 reset = 1'b0;
        m_fail = 0;
`ifdef UNLOCK_SEQ_STATS_EN
        m_ok_tot = 0;
        m_fail_tot = 0;
`endif
        tl[c+1] = idle_e(0);
        m_free = c + 2;
        check({tag, " code_ready after release"}, 32'(code_ready), 32'd1);
        check({tag, " fail_cnt after release"}, 32'(fail_cnt), 32'd0);
    endtask

    task automatic attempt_reset(input logic [W-1:0] code, input int rst_bit);
        int a;
        a = m_free;
        fill_idle(m_free, a);
        fill_front(a, code, rst_bit);
        wait_until(a);
        code_valid = 1'b1;
        code_data = code;
        wait_until(a + 1);
        code_valid = 1'b0;
        wait_until(a + 2 + rst_bit);
        pulse_reset("reset mid-shift");
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nb, op, lk;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        check("reset code_ready", 32'(code_ready), 32'd1);
        check("reset fsm_clear", 32'(fsm_clear), 32'd0);
        check("reset serial_valid", 32'(serial_valid), 32'd0);
        check("reset door_open", 32'(door_open), 32'd0);
        check("reset locked_out", 32'(locked_out), 32'd0);
        check("reset result_valid", 32'(result_valid), 32'd0);
        check("reset fail_cnt", 32'(fail_cnt), 32'd0);
        m_free = cyc;

        // Good code, unlock on the last bit; host keeps offering while busy.
        nb = mon_nbits;
        op = mon_open;
        attempt(4'b1011, 4'b1000, 4'b0000, 2, 1'b1);
        wait_until(m_free);
        check("open bit count", 32'(mon_nbits - nb), 32'd4);
        check("open serial bits", 32'(mon_bits[3:0]), 32'hB);
        check("door_open cycles", 32'(mon_open - op), 32'd50);

        // Rejected on bit 2: bit 3 never sent.
        nb = mon_nbits;
        attempt(4'b1001, 4'b0000, 4'b0100, 0, 1'b0);
        wait_until(m_free);
        check("early reject bit count", 32'(mon_nbits - nb), 32'd3);
        check("early reject bits", 32'(mon_bits[2:0]), 32'h4);
        check("fail_cnt after one failure", 32'(fail_cnt), 32'd1);

        // Unlock before the last bit is ignored.
        attempt(4'b0101, 4'b0111, 4'b0000, 1, 1'b0);
        wait_until(m_free);
        check("fail_cnt after early unlock", 32'(fail_cnt), 32'd2);

        // Both unlock and pwd_incorrect on the last bit: third failure, lockout.
        lk = mon_lock;
        attempt(4'b1110, 4'b1000, 4'b1000, 0, 1'b1);
        wait_until(m_free);
        check("locked_out cycles", 32'(mon_lock - lk), 32'd100);
        check("fail_cnt after lockout", 32'(fail_cnt), 32'd0);

        // Two failures, a success, then two more failures without lockout.
        attempt(4'b0011, 4'b0000, 4'b0001, 0, 1'b0);
        attempt(4'b1100, 4'b0000, 4'b0000, 0, 1'b0);
        wait_until(m_free);
        check("fail_cnt before success", 32'(fail_cnt), 32'd2);
        attempt(4'b0110, 4'b1111, 4'b0000, 0, 1'b0);
        wait_until(m_free);
        check("fail_cnt after success", 32'(fail_cnt), 32'd0);
        attempt(4'b1010, 4'b0000, 4'b0010, 0, 1'b0);
        attempt(4'b0001, 4'b0000, 4'b1000, 0, 1'b0);
        wait_until(m_free);
        check("fail_cnt after two more", 32'(fail_cnt), 32'd2);
        check("no lockout after two more", 32'(locked_out), 32'd0);

        attempt_reset(4'b1101, 1);
        fill_idle(m_free, m_free + 4);
        m_free = m_free + 5;

`ifdef UNLOCK_SEQ_STATS_EN
        wait_until(m_free);
        pulse_reset("stats reset");
        for (int i = 0; i < 300; i++) begin
            case (i % 3)
                0:       attempt(4'(i), 4'b0000, 4'b0001, 0, 1'b0);
                1:       attempt(4'(i), 4'b0111, 4'b0000, 0, 1'b0);
                default: attempt(4'(i), 4'b1000, 4'b1000, 0, 1'b0);
            endcase
            if (i == 99) begin
                wait_until(m_free);
                check("fail_total after 100", 32'(fail_total), 32'd100);
            end
        end
        wait_until(m_free);
        check("fail_total saturated", 32'(fail_total), 32'd255);
        check("fail_total model", 32'(fail_total), 32'(m_fail_tot));
        check("ok_total", 32'(ok_total), 32'd0);
        check("ok_total model", 32'(ok_total), 32'(m_ok_tot));
`endif

        fill_idle(m_free, m_free + 5);
        wait_until(m_free + 6);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/unlock_sequencer.md
UNLOCK_SEQUENCER -- requirements
Module: unlock_sequencer

Interface
REQ-001 SHALL have parameter CODE_W, default 4, meaning bits per code attempt.
REQ-002 SHALL have parameter MAX_FAILS, default 3, meaning consecutive failures that trigger lockout.
REQ-003 SHALL have parameter LOCKOUT_CYCLES, default 100, meaning lockout duration in clk cycles.
REQ-004 SHALL have parameter OPEN_CYCLES, default 50, meaning door_open hold duration in clk cycles.
REQ-005 SHALL have ports: clk  in  1  sole clock; reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports: code_valid  in  1  host attempt offer; code_data  in  CODE_W  attempt code, MSB sent first; code_ready  out  1  attempt accepted when code_valid&code_ready.
REQ-007 SHALL have ports: fsm_clear  out  1  one-cycle clear to the unlock FSM; serial_ready  out  1; serial_valid  out  1; serial_data  out  1  serial bit to the FSM.
REQ-008 SHALL have ports: unlock  in  1; pwd_incorrect  in  1  Mealy outputs of the unlock FSM, valid in the same cycle as serial_valid.
REQ-009 SHALL have ports: door_open  out  1; locked_out  out  1; fail_cnt  out  $clog2(MAX_FAILS+1)  consecutive failures; result_valid  out  1  one-cycle pulse; result_ok  out  1  qualified by result_valid.

Function
REQ-010 SHALL implement states IDLE, CLEAR, SHIFT, OPEN, LOCKOUT.
REQ-011 IDLE: code_ready=1; on handshake, code_data SHALL be latched into a shift register and state -> CLEAR.
REQ-012 CLEAR: fsm_clear=1 for exactly one cycle, bit index reset to 0, state -> SHIFT.
REQ-013 SHIFT: serial_ready=1 and serial_valid=1 every cycle, one bit per cycle, MSB first; serial_valid SHALL be 0 in all other states.
REQ-014 SHIFT: unlock=1 in the cycle of bit CODE_W-1 SHALL count as success -> fail_cnt=0, result_valid=1, result_ok=1, state -> OPEN.
REQ-015 SHIFT: pwd_incorrect=1 on any bit, or neither input asserted on bit CODE_W-1, SHALL count as failure: result_valid=1, result_ok=0, remaining bits dropped, fail_cnt incremented.
REQ-016 On failure, if the incremented fail_cnt equals MAX_FAILS, state SHALL -> LOCKOUT; otherwise state SHALL -> IDLE.
REQ-017 unlock asserted before bit CODE_W-1 SHALL be ignored; unlock and pwd_incorrect both high SHALL count as failure.
REQ-018 OPEN: door_open=1 for exactly OPEN_CYCLES cycles, then state -> IDLE; code_ready=0.
REQ-019 LOCKOUT: locked_out=1 for exactly LOCKOUT_CYCLES cycles, code_ready=0; on exit fail_cnt=0 and state -> IDLE.
REQ-020 fail_cnt SHALL never exceed MAX_FAILS; the duration timer SHALL be sized for max(OPEN_CYCLES, LOCKOUT_CYCLES).
REQ-021 An accept-to-first-bit latency of 2 cycles (handshake cycle, CLEAR cycle) SHALL hold; result_valid SHALL occur in the cycle after the deciding bit.
REQ-022 code_valid while code_ready=0 SHALL be held off by the host and SHALL NOT be latched.

Reset
REQ-023 Asynchronous assertion of reset SHALL force IDLE, clear the shift register, bit index, timer and fail_cnt, and drive all outputs 0 except code_ready=1 on deassertion.
REQ-024 Reset mid-SHIFT, OPEN or LOCKOUT SHALL abandon the attempt or timer with no result_valid pulse.

Configuration
REQ-025 Macro UNLOCK_SEQ_STATS_EN SHALL add outputs ok_total and fail_total (8 bits each), incremented on each result_valid and saturating at 255, cleared by reset.
REQ-026 Without UNLOCK_SEQ_STATS_EN these ports and their counters SHALL be absent; all other behaviour is identical.

Verification
REQ-027 code 4'b1011, FSM unlock on bit 3 -> serial bits 1,0,1,1 on consecutive cycles, result_ok=1, door_open high exactly 50 cycles.
REQ-028 code 4'b1001, pwd_incorrect on bit 2 -> bit 3 never sent, result_ok=0, fail_cnt=1, code_ready=1 next cycle.
REQ-029 Three consecutive failures -> locked_out high exactly 100 cycles, code_valid ignored throughout, fail_cnt=0 after.
REQ-030 Two failures, then success -> fail_cnt returns 0; a further two failures do not trigger lockout.
REQ-031 reset pulse during SHIFT bit 1 -> serial_valid=0 immediately, no result_valid, IDLE with code_ready=1 after release.
REQ-032 With UNLOCK_SEQ_STATS_EN, 300 failing attempts (lockouts included) -> fail_total=255, ok_total=0.
